// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift-left / shift-right / parallel load,
// with a saturating count of shifts since the last load and a drained flag.
// Optional build macro: SHIFT_REG_UNIV_ROTATE_EN turns the shifts into rotates
// (serial inputs ignored, drained held at 0 because no data leaves the register).
// Parameter constraints: WIDTH >= 2 and 2**CNT_W > WIDTH.
module shift_reg_univ #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d_in,
    input  logic             s_in_r,
    input  logic             s_in_l,
    output logic [WIDTH-1:0] q,
    output logic             s_out_l,
    output logic             s_out_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             drained
);

    localparam logic [1:0]       MODE_HOLD  = 2'b00;
    localparam logic [1:0]       MODE_SHL   = 2'b01;
    localparam logic [1:0]       MODE_SHR   = 2'b10;
    localparam logic [1:0]       MODE_LOAD  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             ins_shl;
    logic             ins_shr;

    // Bits entering on a shift: serial inputs, or the wrapped-around end bits when rotating
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    assign ins_shl = q[WIDTH-1];
    assign ins_shr = q[0];
`else
    assign ins_shl = s_in_r;
    assign ins_shr = s_in_l;
`endif

    // Shift count saturates at WIDTH so it never wraps back to "not drained"
    assign cnt_inc = (shift_cnt == CNT_FULL) ? CNT_FULL : shift_cnt + CNT_W'(1);

    // Next-state selection from enable and mode
    always_comb begin
        q_next   = q;
        cnt_next = shift_cnt;
        if (enable) begin
            case (mode)
                MODE_SHL: begin
                    q_next   = {q[WIDTH-2:0], ins_shl};
                    cnt_next = cnt_inc;
                end
                MODE_SHR: begin
                    q_next   = {ins_shr, q[WIDTH-1:1]};
                    cnt_next = cnt_inc;
                end
                MODE_LOAD: begin
                    q_next   = d_in;
                    cnt_next = '0;
                end
                MODE_HOLD: begin
                    q_next   = q;
                    cnt_next = shift_cnt;
                end
                default: begin
                    q_next   = q;
                    cnt_next = shift_cnt;
                end
            endcase
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q         <= '0;
            shift_cnt <= '0;
        end else begin
            q         <= q_next;
            shift_cnt <= cnt_next;
        end
    end

    // Cascade taps: the bit that leaves on the next left / right shift
    assign s_out_l = q[WIDTH-1];
    assign s_out_r = q[0];

    // Drained decode; a rotating register never loses data
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    assign drained = 1'b0;
`else
    assign drained = (shift_cnt == CNT_FULL);
`endif

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parameterised universal shift register (4 bits by default).
- Sits directly downstream of the 2-bit binary counter stage.
- Its 2-bit mode input is driven from the counter's count output, and its enable from the same enable line, so the counter sequences hold / shift-left / shift-right / load operations.
- Also tracks how many shifts have occurred since the last parallel load and flags when loaded data has fully drained.

Parameters:
- WIDTH, 4: register width in bits; minimum 2.
- CNT_W, 3: shift-counter width; must satisfy 2^CNT_W > WIDTH (3 for WIDTH=4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  1 = perform the operation selected by mode this edge; 0 = hold all state.
- mode  input  2  operation select, normally wired to the counter's count: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- d_in  input  WIDTH  parallel load data.
- s_in_r  input  1  serial bit entering at bit 0 on shift left.
- s_in_l  input  1  serial bit entering at bit WIDTH-1 on shift right.
- q  output  WIDTH  register contents (registered).
- s_out_l  output  1  q[WIDTH-1] (combinational from q).
- s_out_r  output  1  q[0] (combinational from q).
- shift_cnt  output  CNT_W  shifts since last load, saturating at WIDTH (registered).
- drained  output  1  1 when shift_cnt == WIDTH (combinational decode of registered shift_cnt).

Behaviour:
- Reset:
  - reset low immediately forces q = 0, shift_cnt = 0, drained = 0, independent of clk.
  - reset low overrides any operation in progress.
  - Release is sampled on the next rising clk; the first operation occurs on the first rising edge with reset high.
- All state updates on rising clk only; latency is 1 cycle from inputs to q / shift_cnt.
- enable = 0: q and shift_cnt hold regardless of mode, d_in and serial inputs.
- enable = 1, per mode:
  - 00 hold: q and shift_cnt unchanged.
  - 01 shift left: q <= {q[WIDTH-2:0], s_in_r}; shift_cnt <= min(shift_cnt+1, WIDTH).
  - 10 shift right: q <= {s_in_l, q[WIDTH-1:1]}; shift_cnt <= min(shift_cnt+1, WIDTH).
  - 11 load: q <= d_in; shift_cnt <= 0, overriding saturation.
- shift_cnt never wraps. Once it reaches WIDTH it stays there until a load or reset, and drained stays 1.
- Left and right shifts count identically; direction changes do not reset the count.
- Serial inputs are sampled only on shift edges; d_in is sampled only on load edges.
- No illegal mode values exist; all 4 encodings are defined.
- s_out_l / s_out_r reflect the bit that leaves on the next left / right shift, so a second instance can be cascaded.

Optional Feature:
- Macro: SHIFT_REG_UNIV_ROTATE_EN.
- Defined:
  - Shift left inserts q[WIDTH-1] at bit 0 (rotate left); shift right inserts q[0] at bit WIDTH-1 (rotate right).
  - s_in_l and s_in_r are ignored.
  - shift_cnt still counts and saturates, but drained is held constant 0, since no data is lost.
- Not defined: serial-insert behaviour as above; drained operates normally.

Test Plan:
- Reset and load: hold reset low with q previously 1111 -> q=0000, shift_cnt=0, drained=0 without a clk edge; release, enable=1, mode=11, d_in=1011 -> next edge q=1011, shift_cnt=0.
- Drain: after a load of 0000, 5 edges of mode=01 with s_in_r=1 -> q=0001,0011,0111,1111,1111; shift_cnt=1,2,3,4,4; drained=1 from the 4th edge on.
- Enable gating: q=0110, enable=0, mode=01/10/11 for 3 edges -> q stays 0110, shift_cnt unchanged.
- Counter-driven sequence: q=0110, enable=1, mode 00,01,10,11 on successive edges, s_in_r=s_in_l=0, d_in=1001 -> q=0110,1100,0110,1001; shift_cnt=k,k+1,k+2,0, where k is shift_cnt before the sequence.
- Async reset mid-shift: drive reset low between clk edges during a mode=01 run -> q=0000 and shift_cnt=0 immediately; the following edge with reset low keeps them 0.
- Rotate: load 1001, mode=01 with s_in_r=0 -> q=0011 with SHIFT_REG_UNIV_ROTATE_EN, q=0010 without; after 4 rotates drained stays 0.
